// File: rtl/lsq_pkg.sv
// lsq_pkg: shared state encoding and op-type constants for the load/store scheduler
package lsq_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;
    localparam logic LD = 1'b0;
    localparam logic ST = 1'b1;
endpackage

// File: rtl/lsq_scheduler_age_picker.sv
// age_picker: circular oldest-first pick; ports vector_i (candidates), head_i (oldest slot), valid_o, index_o
module age_picker #(
    parameter int WIDTH = 2
) (
    input  logic [2**WIDTH-1:0] vector_i,
    input  logic [WIDTH-1:0]    head_i,
    output logic                valid_o,
    output logic [WIDTH-1:0]    index_o
);
    logic [WIDTH-1:0] j;
    always_comb begin
        valid_o = |vector_i;
        index_o = '0;
        j = '0;
        // scan youngest-to-oldest so the entry closest to head is the last one written
        for (int k = 2**WIDTH-1; k >= 0; k--) begin
            j = head_i + WIDTH'(k);
            if (vector_i[j]) index_o = j;
        end
    end
endmodule

// File: rtl/lsq_scheduler.sv
// lsq_scheduler: arbitrates the data-memory port between the committed head store and the oldest ready load; ports i_laq_*/i_saq_* queue status, i_mem_gnt/i_mem_rvalid cache handshake, o_mem_* request, o_issue_*/o_load_wb completion pulses, o_busy
module lsq_scheduler
    import lsq_pkg::*;
#(
    parameter int WIDTH_SAQ  = 2,
    parameter int WIDTH_LAQ  = 2,
    parameter int STARVE_MAX = 8,
    parameter int WIDTH_IDX  = (WIDTH_SAQ > WIDTH_LAQ) ? WIDTH_SAQ : WIDTH_LAQ
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2**WIDTH_LAQ-1:0] i_laq_rdy,
    input  logic [2**WIDTH_LAQ-1:0] i_laq_conflict,
    input  logic [WIDTH_LAQ-1:0]    i_laq_head,
    input  logic [2**WIDTH_SAQ-1:0] i_saq_commit,
    input  logic [WIDTH_SAQ-1:0]    i_saq_head,
    input  logic                    i_flush,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [WIDTH_IDX-1:0]    o_mem_idx,
    output logic [2**WIDTH_LAQ-1:0] o_issue_laq,
    output logic [2**WIDTH_SAQ-1:0] o_issue_saq,
    output logic                    o_load_wb,
    output logic [WIDTH_LAQ-1:0]    o_wb_idx,
    output logic                    o_busy
);
    localparam int SIZE_SAQ = 2**WIDTH_SAQ;
    localparam int SIZE_LAQ = 2**WIDTH_LAQ;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

    state_e                 state_q;
    logic                   we_q;
    logic [WIDTH_IDX-1:0]   idx_q;
    logic [CW-1:0]          starve_q;
    logic [SIZE_LAQ-1:0]    issue_laq_q;
    logic [SIZE_SAQ-1:0]    issue_saq_q;
    logic                   load_wb_q;
    logic [WIDTH_LAQ-1:0]   wb_idx_q;
    logic                   ld_valid;
    logic [WIDTH_LAQ-1:0]   ld_idx;
    logic                   store_wins;

    age_picker #(.WIDTH(WIDTH_LAQ)) u_laq_pick (
        .vector_i (i_laq_rdy & ~i_laq_conflict),
        .head_i   (i_laq_head),
        .valid_o  (ld_valid),
        .index_o  (ld_idx)
    );

    assign store_wins = i_saq_commit[i_saq_head] & (~ld_valid | (starve_q < CMAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= LD;
            idx_q       <= '0;
            starve_q    <= '0;
            issue_laq_q <= '0;
            issue_saq_q <= '0;
            load_wb_q   <= 1'b0;
            wb_idx_q    <= '0;
        end else begin
            issue_laq_q <= '0;
            issue_saq_q <= '0;
            load_wb_q   <= 1'b0;
            case (state_q)
                IDLE: if (!i_flush) begin
                    if (store_wins) begin
                        state_q <= REQ;
                        we_q    <= ST;
                        idx_q   <= WIDTH_IDX'(i_saq_head);
                        // a store can only beat a waiting load while below the cap, so no overflow
                        if (ld_valid) starve_q <= starve_q + 1'b1;
                    end else if (ld_valid) begin
                        state_q  <= REQ;
                        we_q     <= LD;
                        idx_q    <= WIDTH_IDX'(ld_idx);
                        starve_q <= '0;
                    end
                end
                REQ: if (i_mem_gnt) begin
                    if (we_q) issue_saq_q <= SIZE_SAQ'(1) << idx_q[WIDTH_SAQ-1:0];
                    else      issue_laq_q <= SIZE_LAQ'(1) << idx_q[WIDTH_LAQ-1:0];
                    state_q <= we_q ? IDLE : (i_flush ? DRAIN : WAIT);
                end else if (i_flush) begin
                    state_q <= IDLE;
                end
                WAIT: if (i_mem_rvalid) begin
                    // a flush landing with the response discards it rather than waiting for another
                    if (!i_flush) begin
                        load_wb_q <= 1'b1;
                        wb_idx_q  <= idx_q[WIDTH_LAQ-1:0];
                    end
                    state_q <= IDLE;
                end else if (i_flush) begin
                    state_q <= DRAIN;
                end
                DRAIN: if (i_mem_rvalid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mem_req   = (state_q == REQ);
    assign o_mem_we    = o_mem_req & we_q;
    assign o_mem_idx   = o_mem_req ? idx_q : '0;
    assign o_issue_laq = issue_laq_q;
    assign o_issue_saq = issue_saq_q;
    assign o_load_wb   = load_wb_q;
    assign o_wb_idx    = wb_idx_q;
    assign o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_lsq_scheduler.sv
// tb_lsq_scheduler: directed and randomized checks of lsq_scheduler against a transaction-level reference model
module tb_lsq_scheduler;
    localparam int STARVE = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] laq_rdy, laq_conf, saq_commit;
    logic [1:0] laq_head, saq_head;
    logic       flush, gnt, rvalid;
    logic       mem_req, mem_we, load_wb, busy;
    logic [1:0] mem_idx, wb_idx;
    logic [3:0] issue_laq, issue_saq;

    int n_chk = 0;
    int n_fail = 0;

    bit         m_req, m_st, m_wait, m_drop, m_wb;
    int         m_idx, m_starve, m_wbidx;
    logic [3:0] m_iss_l, m_iss_s;

    always #5 clk = ~clk;

    lsq_scheduler #(.WIDTH_SAQ(2), .WIDTH_LAQ(2), .STARVE_MAX(STARVE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_laq_rdy      (laq_rdy),
        .i_laq_conflict (laq_conf),
        .i_laq_head     (laq_head),
        .i_saq_commit   (saq_commit),
        .i_saq_head     (saq_head),
        .i_flush        (flush),
        .i_mem_gnt      (gnt),
        .i_mem_rvalid   (rvalid),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_idx      (mem_idx),
        .o_issue_laq    (issue_laq),
        .o_issue_saq    (issue_saq),
        .o_load_wb      (load_wb),
        .o_wb_idx       (wb_idx),
        .o_busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] rdy, input logic [3:0] conf, input int head);
        for (int o = 0; o < 4; o++)
            if (rdy[(head + o) % 4] && !conf[(head + o) % 4]) return (head + o) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_req = 0; m_st = 0; m_wait = 0; m_drop = 0; m_wb = 0;
        m_idx = 0; m_starve = 0; m_wbidx = 0; m_iss_l = '0; m_iss_s = '0;
    endtask

    task automatic model_edge();
        int c;
        m_iss_l = '0; m_iss_s = '0; m_wb = 0;
        if (m_req) begin
            if (gnt) begin
                if (m_st) m_iss_s = 4'(1 << m_idx);
                else begin
                    m_iss_l = 4'(1 << m_idx);
                    m_wait = 1;
                    m_drop = flush;
                end
                m_req = 0;
            end else if (flush) m_req = 0;
        end else if (m_wait) begin
            if (rvalid) begin
                if (!m_drop && !flush) begin
                    m_wb = 1;
                    m_wbidx = m_idx;
                end
                m_wait = 0;
                m_drop = 0;
            end else if (flush) m_drop = 1;
        end else if (!flush) begin
            c = pick(laq_rdy, laq_conf, int'(laq_head));
            if (saq_commit[saq_head] && (c < 0 || m_starve < STARVE)) begin
                m_req = 1; m_st = 1; m_idx = int'(saq_head);
                if (c >= 0) m_starve++;
            end else if (c >= 0) begin
                m_req = 1; m_st = 0; m_idx = c; m_starve = 0;
            end
        end
    endtask

    task automatic check_all();
        check("mem_req",   mem_req,   m_req);
        check("mem_we",    mem_we,    m_req & m_st);
        check("mem_idx",   mem_idx,   m_req ? m_idx : 0);
        check("issue_laq", issue_laq, m_iss_l);
        check("issue_saq", issue_saq, m_iss_s);
        check("load_wb",   load_wb,   m_wb);
        check("wb_idx",    wb_idx,    m_wbidx);
        check("busy",      busy,      m_req | m_wait);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic quiesce();
        laq_rdy = '0; saq_commit = '0; flush = 0; gnt = 1; rvalid = 1;
        repeat (4) step();
        gnt = 0; rvalid = 0;
        step();
    endtask

    initial begin
        int order[4];
        int n_ord;
        rst_n = 0;
        laq_rdy = '0; laq_conf = '0; saq_commit = '0;
        laq_head = '0; saq_head = '0;
        flush = 0; gnt = 0; rvalid = 0;
        model_reset();
        #3 check_all();
        @(negedge clk) rst_n = 1;
        step();

        // loads only: oldest ready from head 2 wraps to 3
        laq_head = 2; laq_rdy = 4'b1011;
        step();
        check("ld_idx", mem_idx, 3);
        check("ld_we", mem_we, 0);
        laq_rdy = '0; gnt = 1;
        step();
        check("ld_issue", issue_laq, 4'b1000);
        gnt = 0;
        step();
        rvalid = 1;
        step();
        check("ld_wb", load_wb, 1);
        check("ld_wb_idx", wb_idx, 3);
        rvalid = 0;
        step();

        // conflict on slot 3 forces wrap to slot 0
        laq_head = 3; laq_rdy = 4'b1001; laq_conf = 4'b1000;
        step();
        check("cf_idx", mem_idx, 0);
        laq_rdy = '0; laq_conf = '0; gnt = 1;
        step();
        check("cf_issue", issue_laq, 4'b0001);
        gnt = 0; rvalid = 1;
        step();
        check("cf_wb_idx", wb_idx, 0);
        rvalid = 0;
        step();

        // starvation: head store always committed, a load always waiting
        foreach (order[i]) order[i] = 2;
        n_ord = 0;
        saq_head = 0; saq_commit = 4'b0001;
        laq_head = 0; laq_rdy = 4'b0001;
        gnt = 1; rvalid = 1;
        repeat (12) begin
            step();
            if (n_ord < 4 && issue_saq != 0) order[n_ord++] = 1;
            else if (n_ord < 4 && issue_laq != 0) order[n_ord++] = 0;
        end
        check("starve_0", order[0], 1);
        check("starve_1", order[1], 1);
        check("starve_2", order[2], 0);
        check("starve_3", order[3], 1);
        quiesce();

        // committed store that is not the head must not issue
        saq_head = 1; saq_commit = 4'b0001;
        repeat (3) step();
        check("nonhead_req", mem_req, 0);
        saq_commit = '0;
        step();

        // flush while waiting for load data
        laq_head = 0; laq_rdy = 4'b0100;
        step();
        check("fw_idx", mem_idx, 2);
        laq_rdy = '0; gnt = 1;
        step();
        gnt = 0; flush = 1;
        step();
        check("fw_busy", busy, 1);
        flush = 0; rvalid = 1;
        step();
        check("fw_no_wb", load_wb, 0);
        check("fw_idle", busy, 0);
        rvalid = 0;
        step();

        // reset while a request is outstanding
        saq_head = 0; saq_commit = 4'b0001;
        step();
        check("rst_pre_req", mem_req, 1);
        saq_commit = '0;
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        check("rst_req", mem_req, 0);
        @(negedge clk) rst_n = 1;
        step();

        // randomized traffic
        repeat (3000) begin
            laq_rdy    = 4'($urandom);
            laq_conf   = 4'($urandom) & 4'($urandom);
            laq_head   = 2'($urandom);
            saq_commit = 4'($urandom);
            saq_head   = 2'($urandom);
            flush      = ($urandom_range(0, 11) == 0);
            gnt        = 1'($urandom_range(0, 1));
            rvalid     = ($urandom_range(0, 2) == 0);
            step();
        end
        quiesce();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
